shift_serializer_ctrl: RTL

Controller that sequences a WIDTH-bit shift register to serialize parallel bytes onto a single output line. It accepts a word over a valid/ready handshake, parallel-loads its internal shift register, and holds each bit for BIT_CYCLES clocks. It then pulses done and returns to idle. It sits between a byte producer and the serial datapath fed by the team's 8-bit shift register.

---
 rtl/shift_serializer_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/shift_serializer_ctrl.sv
// shift_serializer_ctrl
// ---------------------
// Serializes one WIDTH-bit parallel word onto a single output line.
// A word is taken over a valid/ready handshake and parallel-loaded into an
// internal shift register. Each bit is then held on sout for BIT_CYCLES
// clocks. When the last bit period ends, done pulses for one cycle and the
// controller returns to idle.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   din        parallel word, sampled only on the accept edge
//   din_valid  producer has a word available
//   din_ready  controller can accept a word (decoded from state only)
//   abort      synchronous cancel of the current transfer
//   sout       registered serial data out (IDLE_LEVEL when not shifting)
//   busy       registered, high in SHIFT and DONE
//   done       registered one-cycle pulse after the last bit period
//   bit_idx    registered index of the bit currently on sout, 0 otherwise

module shift_serializer_ctrl #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter int MSB_FIRST  = 0,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     din_valid,
  output logic                     din_ready,
  input  logic                     abort,
  output logic                     sout,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);

  localparam int IW = $clog2(WIDTH);
  localparam int DW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [IW-1:0] BIT_LAST = IW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shifted;
  logic [IW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;

  // Returns the bit of a word that leaves the shift register next.
  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // Shift register contents after one shift step. The vacated position is
  // filled with the idle level so the line never sees stale data.
  always_comb begin
    shreg_shifted = shreg;
    if (MSB_FIRST != 0) begin
      shreg_shifted = {shreg[WIDTH-2:0], IDLE_LEVEL};
    end else begin
      shreg_shifted = {IDLE_LEVEL, shreg[WIDTH-1:1]};
    end
  end

  // The handshake depends on state only, so there is no path from
  // din_valid back to din_ready.
  assign din_ready = (state == IDLE);

  // Main sequencer. The sout and bit_idx registers are loaded with the value
  // that belongs to the next cycle. This way the first data bit is on the
  // line right after the accept edge, and every bit lasts exactly
  // BIT_CYCLES clocks. abort is checked before any other transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      sout    <= IDLE_LEVEL;
      busy    <= 1'b0;
      done    <= 1'b0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          sout    <= IDLE_LEVEL;
          busy    <= 1'b0;
          done    <= 1'b0;
          bit_idx <= '0;
          if (din_valid && !abort) begin
            shreg   <= din;
            bit_cnt <= '0;
            div_cnt <= '0;
            state   <= SHIFT;
            sout    <= out_bit(din);
            busy    <= 1'b1;
          end
        end

        SHIFT: begin
          if (abort) begin
            state   <= IDLE;
            bit_cnt <= '0;
            div_cnt <= '0;
            sout    <= IDLE_LEVEL;
            busy    <= 1'b0;
            bit_idx <= '0;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              state   <= DONE;
              bit_cnt <= '0;
              sout    <= IDLE_LEVEL;
              done    <= 1'b1;
              bit_idx <= '0;
            end else begin
              shreg   <= shreg_shifted;
              bit_cnt <= bit_cnt + 1'b1;
              sout    <= out_bit(shreg_shifted);
              bit_idx <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        DONE: begin
          state   <= IDLE;
          bit_cnt <= '0;
          div_cnt <= '0;
          sout    <= IDLE_LEVEL;
          busy    <= 1'b0;
          done    <= 1'b0;
          bit_idx <= '0;
        end

        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
          div_cnt <= '0;
          sout    <= IDLE_LEVEL;
          busy    <= 1'b0;
          done    <= 1'b0;
          bit_idx <= '0;
        end
      endcase
    end
  end

endmodule
